bitwise_and: RTL and testbench

- Reduction-AND unit over a WIDTH-bit operand vector.
- Primary output `out` is purely combinational: 1 only when every bit of `a` is 1.
- A registered side-path samples the result each enabled clock and provides:
  - a delayed copy of `out`
  - a population count of `a`
  - edge pulses
  - a sticky "all-ones seen" flag
- Used as a match/all-set detector inside datapath control logic.

---
 rtl/bitwise_and.sv | 76 +++++++
 tb/tb_bitwise_and.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/bitwise_and.sv
// Reduction-AND detector: combinational all-ones result plus a registered side-path
// carrying the sampled result, a ones count, edge pulses and a sticky "seen" flag.
module bitwise_and #(
   parameter int WIDTH = 5,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a,
   input  logic             en,
   input  logic             clr,
   output logic             out,
   output logic             out_q,
   output logic [CNT_W-1:0] ones_q,
   output logic             rise_p,
   output logic             fall_p,
   output logic             seen_q
);

   logic             out_q_d;
   logic [CNT_W-1:0] ones_q_d;
   logic             rise_q, rise_d;
   logic             fall_q, fall_d;
   logic             seen_q_d;
   logic [CNT_W-1:0] pop_cnt;

   assign out = &a;

   // CNT_W holds WIDTH exactly, so the running sum can never wrap.
   always_comb begin
      pop_cnt = '0;
      for (int i = 0; i < WIDTH; i++) begin
         pop_cnt = pop_cnt + CNT_W'(a[i]);
      end
   end

   always_comb begin
      out_q_d  = out_q;
      ones_q_d = ones_q;
      rise_d   = 1'b0;
      fall_d   = 1'b0;
      seen_q_d = seen_q;
      if (en) begin
         out_q_d  = out;
         ones_q_d = pop_cnt;
      end
      // clr outranks en for the flag and pulses; the sampled value still moves.
      if (clr) begin
         seen_q_d = 1'b0;
      end else if (en) begin
         rise_d   = out & ~out_q;
         fall_d   = ~out & out_q;
         seen_q_d = seen_q | out;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q  <= 1'b0;
         ones_q <= '0;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
         seen_q <= 1'b0;
      end else begin
         out_q  <= out_q_d;
         ones_q <= ones_q_d;
         rise_q <= rise_d;
         fall_q <= fall_d;
         seen_q <= seen_q_d;
      end
   end

   assign rise_p = rise_q;
   assign fall_p = fall_q;

endmodule

// File: tb/tb_bitwise_and.sv
// Bench for bitwise_and: directed scenarios with literal expectations plus a
// behavioural model compared against the DUT on every falling clock edge.
module tb_bitwise_and;

   localparam int WIDTH = 5;
   localparam int CNT_W = 3;

   // clock / reset
   logic clk = 1'b0;
   logic clk_run = 1'b0;
   logic rst_n = 1'b0;
   always begin
      #5;
      if (clk_run) clk = ~clk;
   end

   logic [WIDTH-1:0] a = '0;
   logic             en = 1'b0;
   logic             clr = 1'b0;
   logic             out, out_q, rise_p, fall_p, seen_q;
   logic [CNT_W-1:0] ones_q;

   bitwise_and #(.WIDTH(WIDTH)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .a      (a),
      .en     (en),
      .clr    (clr),
      .out    (out),
      .out_q  (out_q),
      .ones_q (ones_q),
      .rise_p (rise_p),
      .fall_p (fall_p),
      .seen_q (seen_q)
   );

   int tests_run = 0;
   int tests_failed = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // behavioural model: all-ones test and $countones straight from the rules
   logic             m_out_q, m_rise, m_fall, m_seen;
   logic [CNT_W-1:0] m_ones;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_out_q <= 1'b0; m_ones <= '0; m_rise <= 1'b0; m_fall <= 1'b0; m_seen <= 1'b0;
      end else begin
         if (en) begin
            m_out_q <= (a == {WIDTH{1'b1}});
            m_ones  <= CNT_W'($countones(a));
         end
         if (clr || !en) begin
            m_rise <= 1'b0;
            m_fall <= 1'b0;
            m_seen <= clr ? 1'b0 : m_seen;
         end else begin
            m_rise <= (a == {WIDTH{1'b1}}) && !m_out_q;
            m_fall <= (a != {WIDTH{1'b1}}) && m_out_q;
            m_seen <= m_seen || (a == {WIDTH{1'b1}});
         end
      end
   end

   // scoreboard compare on the non-active edge
   logic chk_on = 1'b0;
   always @(negedge clk) begin
      if (chk_on) begin
         check("cmp_out",    32'(out),    32'(a == {WIDTH{1'b1}}));
         check("cmp_out_q",  32'(out_q),  32'(m_out_q));
         check("cmp_ones_q", 32'(ones_q), 32'(m_ones));
         check("cmp_rise_p", 32'(rise_p), 32'(m_rise));
         check("cmp_fall_p", 32'(fall_p), 32'(m_fall));
         check("cmp_seen_q", 32'(seen_q), 32'(m_seen));
      end
   end

   // driver: apply inputs, take one edge, settle 1 time unit past it
   task automatic cyc(input logic [WIDTH-1:0] av, input logic ev, input logic cv);
      a = av; en = ev; clr = cv;
      @(posedge clk);
      #1;
   endtask

   task automatic check_regs(input string name, input logic oq, input logic [CNT_W-1:0] on,
                             input logic r, input logic f, input logic s);
      check({name, "_out_q"},  32'(out_q),  32'(oq));
      check({name, "_ones_q"}, 32'(ones_q), 32'(on));
      check({name, "_rise_p"}, 32'(rise_p), 32'(r));
      check({name, "_fall_p"}, 32'(fall_p), 32'(f));
      check({name, "_seen_q"}, 32'(seen_q), 32'(s));
   endtask

   logic [WIDTH-1:0] sweep_a [4];
   logic             sweep_e [4];
   logic [WIDTH-1:0] perm [32];

   initial begin
      // combinational sweep with the clock stopped
      sweep_a[0] = 5'b00000; sweep_e[0] = 1'b0;
      sweep_a[1] = 5'b00001; sweep_e[1] = 1'b0;
      sweep_a[2] = 5'b11110; sweep_e[2] = 1'b0;
      sweep_a[3] = 5'b11111; sweep_e[3] = 1'b1;
      for (int i = 0; i < 4; i++) begin
         a = sweep_a[i];
         #10;
         check("sweep_out", 32'(out), 32'(sweep_e[i]));
      end
      check_regs("in_reset", 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);

      // reset then enable
      a = 5'b11111; en = 1'b0;
      clk_run = 1'b1;
      chk_on = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      cyc(5'b11111, 1'b1, 1'b0);
      check_regs("rel_en", 1'b1, 3'd5, 1'b1, 1'b0, 1'b1);
      cyc(5'b11110, 1'b1, 1'b0);
      check_regs("fall", 1'b0, 3'd4, 1'b0, 1'b1, 1'b1);

      // enable gating
      a = 5'b11111; en = 1'b0;
      #1;
      check("gate_out_now", 32'(out), 32'd1);
      for (int i = 0; i < 3; i++) begin
         cyc(5'b11111, 1'b0, 1'b0);
         check_regs("gate", 1'b0, 3'd4, 1'b0, 1'b0, 1'b1);
      end

      // clear priority over enable
      cyc(5'b11111, 1'b1, 1'b1);
      check_regs("clr_pri", 1'b1, 3'd5, 1'b0, 1'b0, 1'b0);
      cyc(5'b11111, 1'b1, 1'b0);
      check_regs("reseen", 1'b1, 3'd5, 1'b0, 1'b0, 1'b1);

      // asynchronous reset between edges
      #2;
      rst_n = 1'b0;
      #1;
      check_regs("async_rst", 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
      check("async_rst_out", 32'(out), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      cyc(5'b11111, 1'b1, 1'b0);
      check_regs("post_rst", 1'b1, 3'd5, 1'b1, 1'b0, 1'b1);

      // all 32 operand values in shuffled order with random en/clr
      for (int i = 0; i < 32; i++) perm[i] = WIDTH'(i);
      for (int i = 31; i > 0; i--) begin
         int j;
         logic [WIDTH-1:0] t;
         j = $urandom_range(0, i);
         t = perm[i]; perm[i] = perm[j]; perm[j] = t;
      end
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < 32; i++) begin
            cyc(perm[i], 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 5) == 0));
         end
      end
      cyc(5'b00011, 1'b1, 1'b0);
      check("pin_ones3", 32'(ones_q), 32'd2);

      @(negedge clk);
      chk_on = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
